button_scan_ctrl: RTL and testbench
===================================

// Module: button_scan_ctrl
// PURPOSE
//  Scans the display-board button shift register (parallel-in/serial-out, 74HC165-type) via
//  SHIFT_LOAD/SHIFT_CLKIN/SHIFT_OUT, debounces each button and exposes state, sticky press
//  flags and an interrupt to the soft CPU over an Avalon-MM slave. Instantiated inside
//  clarvi_soc; its conduit is wired to the display-board shift-register pins at top level.
// PARAMETERS
//  NUM_BUTTONS    16   buttons in chain (1..32); first bit shifted out is button NUM_BUTTONS-1
//  CLK_DIV        25   clk cycles per shift-clock half-period and per load pulse (>=1)
//  SCAN_INTERVAL  50000 idle clk cycles between scans (>=1)
//  DEBOUNCE_SCANS 4    consecutive identical raw samples needed to change stable state (>=1)
// PORTS
//  clk              in   1   system clock
//  reset            in   1   asynchronous, active-high reset
//  shiftreg_loadn   out  1   parallel load strobe to shift register, active low
//  shiftreg_clk     out  1   shift clock; register shifts on rising edge
//  shiftreg_in      in   1   serial data from register; 0 = button pressed
//  avs_address      in   2   word address
//  avs_read         in   1   read strobe
//  avs_readdata     out  32  read data, valid cycle after avs_read
//  avs_write        in   1   write strobe
//  avs_writedata    in   32  write data
//  irq              out  1   level interrupt, active high
// BEHAVIOUR
//  Reset: shiftreg_loadn=1, shiftreg_clk=0, avs_readdata=0, irq=0; stable, history, pressed,
//   irq_en, scan_count all 0 (all buttons released); FSM=IDLE, counters 0. No waitrequest.
//  FSM (one clk per count step):
//   IDLE   : count SCAN_INTERVAL cycles -> LOAD.
//   LOAD   : loadn=0, clk=0 for CLK_DIV cycles -> LOW.
//   LOW    : loadn=1, clk=0 for CLK_DIV cycles; sample shiftreg_in on last cycle into raw bit
//            (NUM_BUTTONS-1-bitcount), inverted (pressed=1). If last bit -> UPDATE else HIGH.
//   HIGH   : clk=1 for CLK_DIV cycles -> LOW (bitcount+1).
//   UPDATE : one cycle; debounce, set pressed flags, scan_count+1 -> IDLE.
//  Scan length LOAD..UPDATE = CLK_DIV*(2*NUM_BUTTONS) + 1 cycles; outputs registered (no glitches).
//  Debounce: per button, history of last DEBOUNCE_SCANS raw samples; stable bit takes raw value
//   in UPDATE when all entries equal it, otherwise unchanged.
//  pressed[i] set in UPDATE on stable[i] 0->1; cleared by write-1 to PRESSED. Same-cycle set and
//   clear: set wins. irq = |(pressed & irq_en), registered (1 cycle after cause).
//  Register map (bits >= NUM_BUTTONS read 0, ignore writes):
//   0 STATE      RO  debounced stable state, 1=held
//   1 PRESSED    RW1C sticky press-edge flags
//   2 IRQ_EN     RW  per-button interrupt enable
//   3 SCAN_COUNT RO  32-bit completed-scan counter, wraps 0xFFFFFFFF->0
//  Read latency fixed 1; read and write to same register same cycle returns pre-write value.
//   Writes to RO registers ignored. Read with write strobe both low: readdata holds last value.
//  Reset mid-scan: outputs return to reset values immediately (async); partial raw data discarded;
//   scanning restarts from IDLE with full SCAN_INTERVAL.
//  Bus access never stalls or perturbs the scan FSM.
// TESTING (NUM_BUTTONS=4, CLK_DIV=2, SCAN_INTERVAL=10, DEBOUNCE_SCANS=2 unless noted)
//  1 Reset release, model all released -> loadn low 2 cycles after 10 idle; 4 clk rising
//    edges?no: 3 rising edges per scan, 17-cycle scan; SCAN_COUNT reads 1 after first scan.
//  2 Hold button 2 (model Q bit=0) 2 scans -> STATE=0x4 after 2nd UPDATE, PRESSED=0x4; after
//    1 scan only STATE=0x0.
//  3 Button 1 toggles every scan (bounce) for 6 scans -> STATE bit1 stays 0, PRESSED=0.
//  4 IRQ_EN=0x4, press button 2 -> irq rises 1 cycle after UPDATE; write PRESSED=0x4 -> irq 0;
//    write 0x4 in same cycle as new set edge -> PRESSED bit stays 1.
//  5 Assert reset during HIGH of bit 1 -> loadn=1, clk=0, irq=0 same cycle; next scan starts
//    10 cycles after release; prior history/STATE cleared.
//  6 Write 0xFFFFFFFF to STATE/SCAN_COUNT, read all regs -> unchanged; bits [31:4] read 0.

Source files
------------

// File: rtl/button_scan_ctrl.sv
// Scans a 74HC165-style button shift register, debounces each button, and
// exposes state, sticky press flags, and a level interrupt over Avalon-MM.
module button_scan_ctrl #(
  parameter int unsigned NUM_BUTTONS    = 16,
  parameter int unsigned CLK_DIV        = 25,
  parameter int unsigned SCAN_INTERVAL  = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        shiftreg_loadn,
  output logic        shiftreg_clk,
  input  logic        shiftreg_in,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        irq
);

  localparam int unsigned CNT_MAX = (SCAN_INTERVAL > CLK_DIV) ? SCAN_INTERVAL : CLK_DIV;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(SCAN_INTERVAL - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NUM_BUTTONS - 1);

  localparam logic [1:0] ADDR_STATE   = 2'd0;
  localparam logic [1:0] ADDR_PRESSED = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN  = 2'd2;
  localparam logic [1:0] ADDR_COUNT   = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH, S_UPDATE} state_t;

  state_t                                     r_state;
  logic [CNT_W-1:0]                           r_cnt;
  logic [BIT_W-1:0]                           r_bitcnt;
  logic                                       r_loadn;
  logic                                       r_sclk;
  logic [NUM_BUTTONS-1:0]                     r_raw;
  logic [DEBOUNCE_SCANS-1:0][NUM_BUTTONS-1:0] r_hist;
  logic [NUM_BUTTONS-1:0]                     r_stable;
  logic [NUM_BUTTONS-1:0]                     r_pressed;
  logic [NUM_BUTTONS-1:0]                     r_irq_en;
  logic [31:0]                                r_scan_count;
  logic [31:0]                                r_readdata;
  logic                                       r_irq;

  logic [DEBOUNCE_SCANS-1:0][NUM_BUTTONS-1:0] w_hist_next;
  logic [NUM_BUTTONS-1:0]                     w_all1;
  logic [NUM_BUTTONS-1:0]                     w_all0;
  logic [NUM_BUTTONS-1:0]                     w_stable_next;
  logic [NUM_BUTTONS-1:0]                     w_set;
  logic [NUM_BUTTONS-1:0]                     w_clr;
  logic [BIT_W-1:0]                           w_raw_idx;
  logic [31:0]                                w_rdata;
  logic                                       w_div_last;

  assign shiftreg_loadn = r_loadn;
  assign shiftreg_clk   = r_sclk;
  assign avs_readdata   = r_readdata;
  assign irq            = r_irq;

  assign w_div_last = (r_cnt == DIV_LAST);
  // First bit shifted out belongs to the highest-numbered button.
  assign w_raw_idx  = BIT_LAST - r_bitcnt;

  // Debounce: a bit changes only when every sample in the window agrees.
  always_comb begin
    w_hist_next    = r_hist;
    w_hist_next[0] = r_raw;
    for (int unsigned k = 1; k < DEBOUNCE_SCANS; k++) begin
      w_hist_next[k] = r_hist[k-1];
    end
    w_all1 = '1;
    w_all0 = '1;
    for (int unsigned k = 0; k < DEBOUNCE_SCANS; k++) begin
      w_all1 = w_all1 & w_hist_next[k];
      w_all0 = w_all0 & ~w_hist_next[k];
    end
    w_stable_next = (r_stable | w_all1) & ~w_all0;
    w_set = (r_state == S_UPDATE) ? (w_stable_next & ~r_stable) : '0;
    w_clr = (avs_write && avs_address == ADDR_PRESSED) ? avs_writedata[NUM_BUTTONS-1:0] : '0;
  end

  always_comb begin
    w_rdata = '0;
    case (avs_address)
      ADDR_STATE:   w_rdata = 32'(r_stable);
      ADDR_PRESSED: w_rdata = 32'(r_pressed);
      ADDR_IRQ_EN:  w_rdata = 32'(r_irq_en);
      ADDR_COUNT:   w_rdata = r_scan_count;
      default:      w_rdata = '0;
    endcase
  end

  // Scan sequencer; output levels are set on state entry so they stay glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bitcnt     <= '0;
      r_loadn      <= 1'b1;
      r_sclk       <= 1'b0;
      r_raw        <= '0;
      r_hist       <= '0;
      r_stable     <= '0;
      r_scan_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_cnt == IDLE_LAST) begin
            r_cnt   <= '0;
            r_state <= S_LOAD;
            r_loadn <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_LOAD: begin
          if (w_div_last) begin
            r_cnt   <= '0;
            r_state <= S_LOW;
            r_loadn <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_LOW: begin
          if (w_div_last) begin
            r_cnt            <= '0;
            r_raw[w_raw_idx] <= ~shiftreg_in;
            if (r_bitcnt == BIT_LAST) begin
              r_state <= S_UPDATE;
            end else begin
              r_state <= S_HIGH;
              r_sclk  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (w_div_last) begin
            r_cnt    <= '0;
            r_state  <= S_LOW;
            r_sclk   <= 1'b0;
            r_bitcnt <= r_bitcnt + BIT_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_UPDATE: begin
          r_state      <= S_IDLE;
          r_bitcnt     <= '0;
          r_hist       <= w_hist_next;
          r_stable     <= w_stable_next;
          r_scan_count <= r_scan_count + 32'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus registers; a press edge in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pressed  <= '0;
      r_irq_en   <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_pressed <= (r_pressed & ~w_clr) | w_set;
      if (avs_write && avs_address == ADDR_IRQ_EN) begin
        r_irq_en <= avs_writedata[NUM_BUTTONS-1:0];
      end
      if (avs_read) begin
        r_readdata <= w_rdata;
      end
      r_irq <= |(r_pressed & r_irq_en);
    end
  end

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Directed bench for button_scan_ctrl with a behavioural 74HC165 model.
module tb_button_scan_ctrl;
  localparam int unsigned N        = 4;
  localparam int unsigned DIV      = 2;
  localparam int unsigned SI       = 10;
  localparam int unsigned DB       = 2;
  localparam int unsigned SCAN_LEN = DIV * 2 * N + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        shiftreg_loadn;
  logic        shiftreg_clk;
  logic        shiftreg_in;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic        irq;

  logic [3:0]  btn_n = 4'b1111;
  logic [3:0]  sr_q;
  int          n_rise = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [3:0]  btn_n;
    logic [31:0] exp_state;
    logic [31:0] exp_pressed;
  } vec_t;
  vec_t tbl [8];

  button_scan_ctrl #(
    .NUM_BUTTONS(N), .CLK_DIV(DIV), .SCAN_INTERVAL(SI), .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk(clk), .reset(reset),
    .shiftreg_loadn(shiftreg_loadn), .shiftreg_clk(shiftreg_clk), .shiftreg_in(shiftreg_in),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Parallel load on loadn fall, shift toward Q7 on shift-clock rise.
  always @(posedge shiftreg_clk or negedge shiftreg_loadn) begin
    if (!shiftreg_loadn) sr_q <= btn_n;
    else                 sr_q <= {sr_q[2:0], 1'b1};
  end
  assign shiftreg_in = sr_q[3];

  always @(posedge shiftreg_clk) n_rise <= n_rise + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic wait_load();
    int k = 0;
    while (shiftreg_loadn !== 1'b0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k >= 60) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_timeout: loadn never went low within 60 cycles");
    end
  endtask

  // Leaves the caller at the first negedge where UPDATE results are visible.
  task automatic scan();
    wait_load();
    repeat (SCAN_LEN) @(negedge clk);
  endtask

  // From a reset-release negedge: loadn must stay high for SI-1 cycles, then drop.
  task automatic idle_to_load(input string tag);
    for (int i = 0; i < int'(SI) - 1; i++) begin
      @(negedge clk);
      check({tag, "_idle_loadn"}, 32'(shiftreg_loadn), 32'd1);
    end
    @(negedge clk);
    check({tag, "_load_start"}, 32'(shiftreg_loadn), 32'd0);
  endtask

  logic [31:0] d;
  int          rise0;

  initial begin
    tbl[0] = '{4'b1011, 32'h0, 32'h0};
    tbl[1] = '{4'b1011, 32'h4, 32'h4};
    tbl[2] = '{4'b1001, 32'h4, 32'h4};
    tbl[3] = '{4'b1011, 32'h4, 32'h4};
    tbl[4] = '{4'b1001, 32'h4, 32'h4};
    tbl[5] = '{4'b1011, 32'h4, 32'h4};
    tbl[6] = '{4'b1001, 32'h4, 32'h4};
    tbl[7] = '{4'b1011, 32'h4, 32'h4};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_loadn", 32'(shiftreg_loadn), 32'd1);
    check("rst_sclk", 32'(shiftreg_clk), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);

    // First scan: timing, shift-clock edge count, scan counter
    reset = 1'b0;
    rise0 = n_rise;
    idle_to_load("t1");
    check("t1_sclk_in_load", 32'(shiftreg_clk), 32'd0);
    @(negedge clk);
    check("t1_load_2nd", 32'(shiftreg_loadn), 32'd0);
    @(negedge clk);
    check("t1_load_end", 32'(shiftreg_loadn), 32'd1);
    repeat (SCAN_LEN - 2) @(negedge clk);
    check("t1_rise_count", 32'(n_rise - rise0), 32'd3);
    rd(2'd3, d); check("t1_scan_count", d, 32'd1);
    rd(2'd0, d); check("t1_state", d, 32'd0);

    // Hold / bounce table: one scan per entry
    for (int i = 0; i < 8; i++) begin
      btn_n = tbl[i].btn_n;
      scan();
      rd(2'd0, d); check($sformatf("tbl%0d_state", i), d, tbl[i].exp_state);
      rd(2'd1, d); check($sformatf("tbl%0d_pressed", i), d, tbl[i].exp_pressed);
    end
    rd(2'd3, d); check("tbl_scan_count", d, 32'd9);

    // Interrupt path
    wr(2'd1, 32'hF);
    rd(2'd1, d); check("t4_pressed_clr", d, 32'd0);
    wr(2'd2, 32'h4);
    rd(2'd2, d); check("t4_irq_en", d, 32'h4);
    btn_n = 4'b1111;
    scan();
    scan();
    rd(2'd0, d); check("t4_released", d, 32'd0);
    btn_n = 4'b1011;
    scan();
    check("t4_irq_idle", 32'(irq), 32'd0);
    rd(2'd0, d); check("t4_one_sample", d, 32'd0);
    scan();
    @(negedge clk);
    check("t4_irq_rise", 32'(irq), 32'd1);
    rd(2'd1, d); check("t4_pressed_set", d, 32'h4);
    wr(2'd1, 32'h4);
    @(negedge clk);
    check("t4_irq_fall", 32'(irq), 32'd0);
    rd(2'd1, d); check("t4_pressed_w1c", d, 32'd0);

    // Clear in the same cycle as a new press edge: set wins
    btn_n = 4'b1111;
    scan();
    scan();
    btn_n = 4'b1011;
    scan();
    wait_load();
    repeat (SCAN_LEN - 1) @(negedge clk);
    avs_address   = 2'd1;
    avs_writedata = 32'h4;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
    rd(2'd1, d); check("t4_set_wins", d, 32'h4);
    @(negedge clk);
    check("t4_irq_after_set", 32'(irq), 32'd1);

    // Reset during the high phase of bit 1
    wait_load();
    repeat (8) @(negedge clk);
    check("t5_in_high", 32'(shiftreg_clk), 32'd1);
    check("t5_irq_before", 32'(irq), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t5_rst_loadn", 32'(shiftreg_loadn), 32'd1);
    check("t5_rst_sclk", 32'(shiftreg_clk), 32'd0);
    check("t5_rst_irq", 32'(irq), 32'd0);
    check("t5_rst_readdata", avs_readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_to_load("t5");
    repeat (SCAN_LEN) @(negedge clk);
    rd(2'd0, d); check("t5_state_cleared", d, 32'd0);
    rd(2'd1, d); check("t5_pressed", d, 32'd0);
    rd(2'd2, d); check("t5_irq_en", d, 32'd0);
    rd(2'd3, d); check("t5_scan_count", d, 32'd1);

    // Read-only registers, unused bits, read-during-write, readdata hold
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd0, d); check("t6_state_ro", d, 32'd0);
    rd(2'd1, d); check("t6_pressed", d, 32'd0);
    rd(2'd2, d); check("t6_irq_en_mask", d, 32'hF);
    rd(2'd3, d); check("t6_count_ro", d, 32'd1);
    avs_address   = 2'd2;
    avs_writedata = 32'd0;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    check("t6_rw_prewrite", avs_readdata, 32'hF);
    @(negedge clk);
    check("t6_rdata_hold", avs_readdata, 32'hF);
    rd(2'd2, d); check("t6_irq_en_written", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
